// File: rtl/minicpu_pkg.sv
// Shared definitions for the MiniCPU instruction sequencer: opcodes, the idle
// NOP word and the sequencer state encoding.
package minicpu_pkg;

    localparam int INSTR_W = 12;

    localparam logic [3:0] OP_CLR  = 4'b0000;
    localparam logic [3:0] OP_LD1  = 4'b0001;
    localparam logic [3:0] OP_LD2  = 4'b0010;
    localparam logic [3:0] OP_MOV2 = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Driven whenever no program word is presented; OP_CLR would wipe the core.
    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 8'h00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-4] == OP_HALT;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: DEPTH x 12-bit words, synchronous write,
// asynchronous read. Contents survive reset.
module seq_prog_mem
    import minicpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic               clock,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/minicpu_sequencer.sv
// Issues a loaded program to the MiniCPU, one word per HOLD_CYCLES clocks,
// with pause, HALT/end-of-memory termination and fully registered outputs.
module minicpu_sequencer
    import minicpu_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 2 ** ADDR_W,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               pause,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state_o
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               halt_q, halt_d;

    logic               mem_we;
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_word;
    logic               at_last_hold;

    assign at_last_hold = (cnt_q == CNT_LAST);
    assign mem_we       = prog_we && (state_q != ST_RUN);

    // Single read port: word 0 for a start, the successor on the last hold
    // clock (advance/HALT test), otherwise the current word for re-presentation.
    assign rd_addr = (state_q == ST_RUN)
                   ? (at_last_hold ? pc_q + ADDR_W'(1) : pc_q)
                   : '0;

    seq_prog_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !prog_we) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    // A HALT at address 0 enters RUN silently and finishes next clock.
                    if (is_halt(rd_word)) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        halt_d  = 1'b1;
                    end else begin
                        instr_d = rd_word;
                        valid_d = 1'b1;
                        halt_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (halt_q) begin
                    state_d = ST_DONE;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    halt_d  = 1'b0;
                end else if (pause) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (at_last_hold) begin
                    if (pc_q == PC_LAST || is_halt(rd_word)) begin
                        state_d = ST_DONE;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        instr_d = rd_word;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    instr_d = rd_word;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            halt_q  <= halt_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_minicpu_sequencer.sv
// Bench for minicpu_sequencer: unit 0 uses HOLD_CYCLES=2, unit 1 HOLD_CYCLES=1.
// Expected streams come from a list-of-addresses / clocks-served model.
module tb_minicpu_sequencer;
    import minicpu_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start [2];
    logic        pause [2];
    logic        prog_we [2];
    logic [3:0]  prog_addr [2];
    logic [11:0] prog_data [2];
    logic [11:0] instr [2];
    logic        instr_valid [2];
    logic [3:0]  pc [2];
    logic        busy [2];
    logic        done [2];
    state_t      dbg [2];

    logic [11:0] mem_m [2][DEPTH];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    minicpu_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we[0]), .prog_addr(prog_addr[0]),
        .prog_data(prog_data[0]), .start(start[0]), .pause(pause[0]), .instr(instr[0]),
        .instr_valid(instr_valid[0]), .pc(pc[0]), .busy(busy[0]), .done(done[0]),
        .dbg_state_o(dbg[0])
    );

    minicpu_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .prog_we(prog_we[1]), .prog_addr(prog_addr[1]),
        .prog_data(prog_data[1]), .start(start[1]), .pause(pause[1]), .instr(instr[1]),
        .instr_valid(instr_valid[1]), .pc(pc[1]), .busy(busy[1]), .done(done[1]),
        .dbg_state_o(dbg[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_out(input int u, input string tag, input logic [11:0] e_instr,
                              input logic e_valid, input logic [3:0] e_pc,
                              input logic e_busy, input logic e_done);
        chk($sformatf("%s.u%0d.instr", tag, u), 32'(instr[u]), 32'(e_instr));
        chk($sformatf("%s.u%0d.valid", tag, u), 32'(instr_valid[u]), 32'(e_valid));
        chk($sformatf("%s.u%0d.pc", tag, u), 32'(pc[u]), 32'(e_pc));
        chk($sformatf("%s.u%0d.busy", tag, u), 32'(busy[u]), 32'(e_busy));
        chk($sformatf("%s.u%0d.done", tag, u), 32'(done[u]), 32'(e_done));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_word(input int u, input int a, input logic [11:0] d);
        prog_we[u]   = 1'b1;
        prog_addr[u] = 4'(a);
        prog_data[u] = d;
        @(negedge clock);
        prog_we[u]   = 1'b0;
        mem_m[u][a]  = d;
    endtask

    // Starts unit u and checks every clock against the model. Pause is forced
    // for edges [p_from, p_from+p_len) and random at pause_pct percent.
    // stop_at >= 0 returns just before that edge (caller resets there);
    // wr_at >= 0 attempts a program write during the run (must be ignored).
    // done_edge reports the first edge after start at which the DUT showed done.
    task automatic run_prog(input int u, input string tag, input int pause_pct,
                            input int p_from, input int p_len, input int stop_at,
                            input int wr_at, output int done_edge);
        int          seq[$];
        int          idx, served, hold, extra;
        bit          fin, p;
        logic [11:0] e_instr;
        logic        e_valid;
        logic [3:0]  e_pc;

        hold = (u == 0) ? 2 : 1;
        seq.delete();
        for (int a = 0; a < DEPTH; a++) begin
            if (mem_m[u][a][11:8] == OP_HALT) break;
            seq.push_back(a);
        end
        done_edge = -1;
        fin = 0; extra = 0; idx = 0; served = 1; e_pc = '0;

        start[u] = 1'b1;
        pause[u] = (pause_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
        @(negedge clock);
        start[u] = 1'b0;
        if (seq.size() == 0) begin
            e_instr = NOP_WORD; e_valid = 1'b0;
        end else begin
            e_instr = mem_m[u][0]; e_valid = 1'b1;
        end
        expect_out(u, $sformatf("%s.e0", tag), e_instr, e_valid, e_pc, 1'b1, 1'b0);

        for (int j = 1; j < 200; j++) begin
            p = (j >= p_from && j < p_from + p_len) ||
                (pause_pct > 0 && $urandom_range(99) < pause_pct);
            if (j == stop_at) begin
                pause[u] = 1'b0;
                return;
            end
            pause[u] = p;
            if (j == wr_at) begin
                prog_we[u] = 1'b1; prog_addr[u] = 4'd2; prog_data[u] = 12'hF55;
            end
            @(negedge clock);
            prog_we[u] = 1'b0;
            if (done[u] === 1'b1 && done_edge < 0) done_edge = j;

            if (!fin) begin
                if (seq.size() == 0) begin
                    fin = 1;
                end else if (p) begin
                    e_instr = NOP_WORD; e_valid = 1'b0;
                end else if (served < hold) begin
                    served++;
                    e_instr = mem_m[u][seq[idx]]; e_valid = 1'b1;
                end else if (idx + 1 == seq.size()) begin
                    fin = 1;
                end else begin
                    idx++;
                    served  = 1;
                    e_pc    = 4'(seq[idx]);
                    e_instr = mem_m[u][seq[idx]]; e_valid = 1'b1;
                end
            end
            if (fin) begin
                expect_out(u, $sformatf("%s.e%0d", tag, j), NOP_WORD, 1'b0, e_pc, 1'b0, 1'b1);
                extra++;
                if (extra == 3) break;
            end else begin
                expect_out(u, $sformatf("%s.e%0d", tag, j), e_instr, e_valid, e_pc, 1'b1, 1'b0);
            end
        end
        pause[u] = 1'b0;
        chk($sformatf("%s.u%0d.end_done", tag, u), 32'(done[u]), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int de;
        logic [3:0] op;

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; pause[u] = 1'b0; prog_we[u] = 1'b0;
            prog_addr[u] = '0; prog_data[u] = '0;
            for (int a = 0; a < DEPTH; a++) mem_m[u][a] = 12'hF00;
        end
        do_reset();
        for (int u = 0; u < 2; u++) begin
            expect_out(u, "reset", NOP_WORD, 1'b0, 4'd0, 1'b0, 1'b0);
            chk($sformatf("reset.u%0d.state", u), 32'(dbg[u]), 32'(ST_IDLE));
        end
        for (int a = 0; a < DEPTH; a++) begin
            write_word(0, a, 12'hF00);
            write_word(1, a, 12'hF00);
        end

        // Directed load-and-run program.
        write_word(0, 0, 12'h000);
        write_word(0, 1, 12'h107);
        write_word(0, 2, 12'h208);
        write_word(0, 3, 12'h400);
        write_word(0, 4, 12'hF00);
        run_prog(0, "load", 0, -1, 0, -1, -1, de);
        chk("load.done_edge", 32'(de), 32'd8);

        // Pause for three clocks during the first hold clock of 208.
        run_prog(0, "pause", 0, 5, 3, -1, -1, de);
        chk("pause.done_edge", 32'(de), 32'd11);

        // start together with prog_we in IDLE: write lands, start ignored.
        do_reset();
        prog_we[0] = 1'b1; prog_addr[0] = 4'd3; prog_data[0] = 12'h455; start[0] = 1'b1;
        @(negedge clock);
        prog_we[0] = 1'b0; start[0] = 1'b0;
        mem_m[0][3] = 12'h455;
        expect_out(0, "coll", NOP_WORD, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("coll.state", 32'(dbg[0]), 32'(ST_IDLE));
        run_prog(0, "coll_run", 0, -1, 0, -1, -1, de);

        // prog_we during RUN must not change memory; the rerun proves it.
        run_prog(0, "runwr", 0, -1, 0, -1, 3, de);
        run_prog(0, "rerun", 0, -1, 0, -1, -1, de);
        chk("rerun.done_edge", 32'(de), 32'd8);

        // Reset while 208 is being issued, then replay.
        run_prog(0, "rst", 0, -1, 0, 5, -1, de);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expect_out(0, "rst_idle", NOP_WORD, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_idle.state", 32'(dbg[0]), 32'(ST_IDLE));
        run_prog(0, "replay", 0, -1, 0, -1, -1, de);
        chk("replay.done_edge", 32'(de), 32'd8);

        // Full memory, no HALT: 16 issues and no wrap.
        for (int a = 0; a < DEPTH; a++) write_word(0, a, {OP_OR, 8'($urandom)});
        run_prog(0, "full", 0, -1, 0, -1, -1, de);
        chk("full.done_edge", 32'(de), 32'd32);
        chk("full.pc_last", 32'(pc[0]), 32'd15);

        // HOLD_CYCLES = 1 with HALT at address 0.
        write_word(1, 0, 12'hF00);
        run_prog(1, "h1halt", 0, -1, 0, -1, -1, de);
        chk("h1halt.done_edge", 32'(de), 32'd1);

        // Random programs with random pauses on both units.
        for (int r = 0; r < 6; r++) begin
            for (int u = 0; u < 2; u++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    op = ($urandom_range(11) == 0) ? OP_HALT : 4'($urandom_range(14));
                    write_word(u, a, {op, 8'($urandom)});
                end
                run_prog(u, $sformatf("rand%0d", r), 30, -1, 0, -1, -1, de);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
